// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiplier and restoring divider behind a valid/ready issue port.
// Define DIAD_EX_DIV_EN to build the divider; without it every divide op completes immediately with result 0, V=1.
module ex_muldiv #(
    parameter int W     = 24,
    parameter int TGT_W = 4
) (
    input  logic             iw_clk,
    input  logic             iw_rst,
    input  logic             iw_valid,
    output logic             ow_ready,
    input  logic [2:0]       iw_op,
    input  logic [W-1:0]     iw_a,
    input  logic [W-1:0]     iw_b,
    input  logic [TGT_W-1:0] iw_tgt_gp,
    input  logic             iw_flush,
    output logic             ow_valid,
    output logic [W-1:0]     ow_result,
    output logic [TGT_W-1:0] ow_tgt_gp,
    output logic [3:0]       ow_fl
);

    // state  | meaning
    // IDLE   | waiting for an op
    // MUL    | shift-add iterations, one multiplier bit per cycle
    // DIV    | restoring iterations, one quotient bit per cycle
    // DONE   | result presented with ow_valid; may accept the next op
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef DIAD_EX_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     opnd_q;
    logic [TGT_W-1:0] tgt_q;
    logic             sel_hi_q;
    logic             sgn_q;
    logic             neg_q;

    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic           fast;
    logic [W-1:0]   fast_res;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_nx, prod_s;
    logic [W-1:0]   mul_hi, mul_lo, mul_res;
    logic           mul_c;

    assign ow_ready = ((state == S_IDLE) || (state == S_DONE)) && !iw_rst;

    assign a_neg = iw_op[1] & iw_a[W-1];
    assign b_neg = iw_op[1] & iw_b[W-1];
    assign a_mag = a_neg ? -iw_a : iw_a;
    assign b_mag = b_neg ? -iw_b : iw_b;

    // Multiplier: acc holds {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign mul_nx  = {mul_sum, acc[W-1:1]};
    assign prod_s  = neg_q ? -mul_nx : mul_nx;
    assign mul_hi  = prod_s[2*W-1:W];
    assign mul_lo  = prod_s[W-1:0];
    assign mul_res = sel_hi_q ? mul_hi : mul_lo;
    assign mul_c   = sgn_q ? (mul_hi != {W{mul_lo[W-1]}}) : (mul_hi != '0);

`ifdef DIAD_EX_DIV_EN
    logic           rneg_q;
    logic [W:0]     trial;
    logic           div_ge;
    logic [W-1:0]   rem_nx, quo_nx, div_res;
    logic [2*W-1:0] div_nx;
    logic           div_zero, div_ovf;

    // Divider: acc holds {partial remainder, dividend bits shifting into quotient}
    assign trial   = {acc[2*W-1:W], acc[W-1]};
    assign div_ge  = trial >= {1'b0, opnd_q};
    assign rem_nx  = div_ge ? (trial[W-1:0] - opnd_q) : trial[W-1:0];
    assign quo_nx  = {acc[W-2:0], div_ge};
    assign div_nx  = {rem_nx, quo_nx};
    assign div_res = sel_hi_q ? (rneg_q ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);

    assign div_zero = (iw_b == '0);
    assign div_ovf  = iw_op[1] & (iw_a == {1'b1, {(W-1){1'b0}}}) & (&iw_b);
    assign fast     = iw_op[2] & (div_zero | div_ovf);
    assign fast_res = div_zero ? (iw_op[0] ? iw_a : '1) : (iw_op[0] ? '0 : iw_a);
`else
    assign fast     = iw_op[2];
    assign fast_res = '0;
`endif

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state     <= S_IDLE;
            count     <= '0;
            acc       <= '0;
            opnd_q    <= '0;
            tgt_q     <= '0;
            sel_hi_q  <= 1'b0;
            sgn_q     <= 1'b0;
            neg_q     <= 1'b0;
`ifdef DIAD_EX_DIV_EN
            rneg_q    <= 1'b0;
`endif
            ow_valid  <= 1'b0;
            ow_result <= '0;
            ow_tgt_gp <= '0;
            ow_fl     <= '0;
        end else begin
            ow_valid <= 1'b0;
            if (iw_flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        state <= S_IDLE;
                        if (iw_valid) begin
                            count    <= CW'(W);
                            tgt_q    <= iw_tgt_gp;
                            sel_hi_q <= iw_op[0];
                            sgn_q    <= iw_op[1];
                            neg_q    <= a_neg ^ b_neg;
`ifdef DIAD_EX_DIV_EN
                            rneg_q   <= a_neg;
`endif
                            if (fast) begin
                                state     <= S_DONE;
                                ow_valid  <= 1'b1;
                                ow_result <= fast_res;
                                ow_tgt_gp <= iw_tgt_gp;
                                ow_fl     <= {1'b1, fast_res[W-1], 1'b0, fast_res == '0};
                            end
`ifdef DIAD_EX_DIV_EN
                            else if (iw_op[2]) begin
                                state  <= S_DIV;
                                acc    <= {{W{1'b0}}, a_mag};
                                opnd_q <= b_mag;
                            end
`endif
                            else begin
                                state  <= S_MUL;
                                acc    <= {{W{1'b0}}, b_mag};
                                opnd_q <= a_mag;
                            end
                        end
                    end
                    S_MUL: begin
                        acc   <= mul_nx;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state     <= S_DONE;
                            ow_valid  <= 1'b1;
                            ow_result <= mul_res;
                            ow_tgt_gp <= tgt_q;
                            ow_fl     <= {1'b0, mul_res[W-1], mul_c, mul_res == '0};
                        end
                    end
`ifdef DIAD_EX_DIV_EN
                    S_DIV: begin
                        acc   <= div_nx;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state     <= S_DONE;
                            ow_valid  <= 1'b1;
                            ow_result <= div_res;
                            ow_tgt_gp <= tgt_q;
                            ow_fl     <= {1'b0, div_res[W-1], 1'b0, div_res == '0};
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
